// File: rtl/cheri_bp_resolve_sink_pkg.sv
// Shared types for the resolved-branch sink: capability fields, control-flow kinds, update entries.
package cheri_bp_resolve_sink_pkg;

    localparam int unsigned VLEN     = 64;
    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned UPERMS_W = 4;
    localparam int unsigned HPERMS_W = 12;
    localparam int unsigned OTYPE_W  = 18;
    localparam int unsigned EXP_W    = 6;

    typedef logic                bool_t;
    typedef logic [UPERMS_W-1:0] upermsw_t;
    typedef logic [HPERMS_W-1:0] cap_hperms_t;
    typedef logic                cap_flags_t;
    typedef logic [OTYPE_W-1:0]  otypew_t;
    typedef logic                cap_fmt_t;
    typedef logic [EXP_W-1:0]    ew_t;
    typedef logic [ADDR_W-1:0]   addrw_t;
    typedef logic [VLEN-1:0]     vaddr_t;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    // Decoded capability, forwarded untouched from branch unit to frontend
    typedef struct packed {
        bool_t       tag;
        upermsw_t    uperms;
        cap_hperms_t hperms;
        cap_flags_t  cap_mode;
        otypew_t     otype;
        cap_fmt_t    int_e;
        ew_t         exp;
        addrw_t      top;
        addrw_t      base;
        addrw_t      addr;
    } cap_t;

    // Predictor-table update: kind 0 = BHT (uses taken), kind 1 = BTB (uses target)
    typedef struct packed {
        logic   kind;
        vaddr_t pc;
        logic   taken;
        vaddr_t target;
    } upd_entry_t;

endpackage

// File: rtl/cheri_bp_resolve_sink_if.sv
// Bundle of resolved-branch input, redirect and update handshakes, and counters.
interface cheri_bp_resolve_sink_if
    import cheri_bp_resolve_sink_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);

    logic        flush_i;
    logic        resolved_branch_valid_i;
    vaddr_t      resolved_branch_pc_i;
    bool_t       resolved_branch_target_address_tag_i;
    upermsw_t    resolved_branch_target_address_uperms_i;
    cap_hperms_t resolved_branch_target_address_hperms_i;
    cap_flags_t  resolved_branch_target_address_cap_mode_i;
    otypew_t     resolved_branch_target_address_otype_i;
    cap_fmt_t    resolved_branch_target_address_int_e_i;
    ew_t         resolved_branch_target_address_exp_i;
    addrw_t      resolved_branch_target_address_top_i;
    addrw_t      resolved_branch_target_address_base_i;
    addrw_t      resolved_branch_target_address_addr_i;
    logic        resolved_branch_is_mispredict_i;
    logic        resolved_branch_is_taken_i;
    cf_t         resolved_branch_cf_type_i;

    logic        redirect_valid_o;
    logic        redirect_ready_i;
    vaddr_t      redirect_pc_o;
    bool_t       redirect_pcc_tag_o;
    upermsw_t    redirect_pcc_uperms_o;
    cap_hperms_t redirect_pcc_hperms_o;
    cap_flags_t  redirect_pcc_cap_mode_o;
    otypew_t     redirect_pcc_otype_o;
    cap_fmt_t    redirect_pcc_int_e_o;
    ew_t         redirect_pcc_exp_o;
    addrw_t      redirect_pcc_top_o;
    addrw_t      redirect_pcc_base_o;
    addrw_t      redirect_pcc_addr_o;

    logic        upd_valid_o;
    logic        upd_ready_i;
    logic        upd_kind_o;
    vaddr_t      upd_pc_o;
    logic        upd_taken_o;
    vaddr_t      upd_target_o;

    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispredict_cnt_o;
    logic [CNT_W-1:0] dropped_cnt_o;

    // Sink side
    modport slave (
        input  flush_i, resolved_branch_valid_i, resolved_branch_pc_i,
               resolved_branch_target_address_tag_i, resolved_branch_target_address_uperms_i,
               resolved_branch_target_address_hperms_i, resolved_branch_target_address_cap_mode_i,
               resolved_branch_target_address_otype_i, resolved_branch_target_address_int_e_i,
               resolved_branch_target_address_exp_i, resolved_branch_target_address_top_i,
               resolved_branch_target_address_base_i, resolved_branch_target_address_addr_i,
               resolved_branch_is_mispredict_i, resolved_branch_is_taken_i, resolved_branch_cf_type_i,
               redirect_ready_i, upd_ready_i,
        output redirect_valid_o, redirect_pc_o,
               redirect_pcc_tag_o, redirect_pcc_uperms_o, redirect_pcc_hperms_o,
               redirect_pcc_cap_mode_o, redirect_pcc_otype_o, redirect_pcc_int_e_o,
               redirect_pcc_exp_o, redirect_pcc_top_o, redirect_pcc_base_o, redirect_pcc_addr_o,
               upd_valid_o, upd_kind_o, upd_pc_o, upd_taken_o, upd_target_o,
               branch_cnt_o, mispredict_cnt_o, dropped_cnt_o
    );

    // Branch unit / frontend / predictor side
    modport master (
        output flush_i, resolved_branch_valid_i, resolved_branch_pc_i,
               resolved_branch_target_address_tag_i, resolved_branch_target_address_uperms_i,
               resolved_branch_target_address_hperms_i, resolved_branch_target_address_cap_mode_i,
               resolved_branch_target_address_otype_i, resolved_branch_target_address_int_e_i,
               resolved_branch_target_address_exp_i, resolved_branch_target_address_top_i,
               resolved_branch_target_address_base_i, resolved_branch_target_address_addr_i,
               resolved_branch_is_mispredict_i, resolved_branch_is_taken_i, resolved_branch_cf_type_i,
               redirect_ready_i, upd_ready_i,
        input  redirect_valid_o, redirect_pc_o,
               redirect_pcc_tag_o, redirect_pcc_uperms_o, redirect_pcc_hperms_o,
               redirect_pcc_cap_mode_o, redirect_pcc_otype_o, redirect_pcc_int_e_o,
               redirect_pcc_exp_o, redirect_pcc_top_o, redirect_pcc_base_o, redirect_pcc_addr_o,
               upd_valid_o, upd_kind_o, upd_pc_o, upd_taken_o, upd_target_o,
               branch_cnt_o, mispredict_cnt_o, dropped_cnt_o
    );

endinterface

// File: rtl/cheri_bp_resolve_sink.sv
// Consumer of resolved branches: PCC redirect handshake, predictor update FIFO, perf counters.
module cheri_bp_resolve_sink
    import cheri_bp_resolve_sink_pkg::*;
#(
    parameter int unsigned UPD_DEPTH = 4,   // power of two, >= 2
    parameter int unsigned CNT_W     = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    cheri_bp_resolve_sink_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(UPD_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state_q;
    vaddr_t           redir_pc_q;
    cap_t             redir_cap_q;

    upd_entry_t       mem_q [UPD_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;

    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;
    logic [CNT_W-1:0] dropped_cnt_q;

    cap_t       in_cap_c;
    upd_entry_t entry_c;
    upd_entry_t head_c;
    logic       accept_c;
    logic       wrong_path_c;
    logic       is_bht_c;
    logic       is_btb_c;
    logic       full_c;
    logic       push_c;
    logic       pop_c;
    logic       fifo_drop_c;

    // Gather the flattened target capability into one record
    assign in_cap_c = '{
        tag:      bus.resolved_branch_target_address_tag_i,
        uperms:   bus.resolved_branch_target_address_uperms_i,
        hperms:   bus.resolved_branch_target_address_hperms_i,
        cap_mode: bus.resolved_branch_target_address_cap_mode_i,
        otype:    bus.resolved_branch_target_address_otype_i,
        int_e:    bus.resolved_branch_target_address_int_e_i,
        exp:      bus.resolved_branch_target_address_exp_i,
        top:      bus.resolved_branch_target_address_top_i,
        base:     bus.resolved_branch_target_address_base_i,
        addr:     bus.resolved_branch_target_address_addr_i
    };

    // Acceptance only in IDLE; anything valid while a redirect is pending is wrong-path
    always_comb begin
        accept_c     = 1'b0;
        wrong_path_c = 1'b0;
        is_bht_c     = 1'b0;
        is_btb_c     = 1'b0;
        entry_c      = '0;
        if (bus.resolved_branch_valid_i && !bus.flush_i) begin
            accept_c     = (state_q == IDLE);
            wrong_path_c = (state_q == HOLD);
        end
        is_bht_c       = (bus.resolved_branch_cf_type_i == Branch);
        is_btb_c       = (bus.resolved_branch_cf_type_i == JumpR);
        entry_c.kind   = is_btb_c;
        entry_c.pc     = bus.resolved_branch_pc_i;
        entry_c.taken  = is_bht_c & bus.resolved_branch_is_taken_i;
        entry_c.target = is_btb_c ? bus.resolved_branch_target_address_addr_i[VLEN-1:0] : '0;
    end

    // Full is judged on registered occupancy, so a same-cycle pop does not make room
    always_comb begin
        full_c      = (occ_q == OCC_W'(UPD_DEPTH));
        pop_c       = (occ_q != '0) && bus.upd_ready_i;
        push_c      = accept_c && (is_bht_c || is_btb_c) && !full_c;
        fifo_drop_c = accept_c && (is_bht_c || is_btb_c) && full_c;
    end

    // Redirect FSM: latch PC and target on an accepted mispredict, hold until ready or flush
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            redir_pc_q  <= '0;
            redir_cap_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c && bus.resolved_branch_is_mispredict_i) begin
                        state_q     <= HOLD;
                        redir_pc_q  <= bus.resolved_branch_pc_i;
                        redir_cap_q <= in_cap_c;
                    end
                end
                HOLD: begin
                    if (bus.flush_i || bus.redirect_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Update FIFO storage and pointers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= entry_c;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating performance counters; FIFO and wrong-path drops are mutually exclusive
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
            dropped_cnt_q    <= '0;
        end else begin
            if (accept_c && (bus.resolved_branch_cf_type_i != NoCF)) begin
                branch_cnt_q <= sat_inc(branch_cnt_q);
            end
            if (accept_c && bus.resolved_branch_is_mispredict_i) begin
                mispredict_cnt_q <= sat_inc(mispredict_cnt_q);
            end
            if (wrong_path_c || fifo_drop_c) begin
                dropped_cnt_q <= sat_inc(dropped_cnt_q);
            end
        end
    end

    assign head_c = mem_q[rd_ptr_q];

    assign bus.redirect_valid_o        = (state_q == HOLD);
    assign bus.redirect_pc_o           = redir_pc_q;
    assign bus.redirect_pcc_tag_o      = redir_cap_q.tag;
    assign bus.redirect_pcc_uperms_o   = redir_cap_q.uperms;
    assign bus.redirect_pcc_hperms_o   = redir_cap_q.hperms;
    assign bus.redirect_pcc_cap_mode_o = redir_cap_q.cap_mode;
    assign bus.redirect_pcc_otype_o    = redir_cap_q.otype;
    assign bus.redirect_pcc_int_e_o    = redir_cap_q.int_e;
    assign bus.redirect_pcc_exp_o      = redir_cap_q.exp;
    assign bus.redirect_pcc_top_o      = redir_cap_q.top;
    assign bus.redirect_pcc_base_o     = redir_cap_q.base;
    assign bus.redirect_pcc_addr_o     = redir_cap_q.addr;

    assign bus.upd_valid_o  = (occ_q != '0);
    assign bus.upd_kind_o   = head_c.kind;
    assign bus.upd_pc_o     = head_c.pc;
    assign bus.upd_taken_o  = head_c.taken;
    assign bus.upd_target_o = head_c.target;

    assign bus.branch_cnt_o     = branch_cnt_q;
    assign bus.mispredict_cnt_o = mispredict_cnt_q;
    assign bus.dropped_cnt_o    = dropped_cnt_q;

endmodule
